mult_ctrl: RTL
==============

// Module: mult_ctrl
// PURPOSE
//  Control FSM for the shift-add multiplier; sits directly upstream of ACC and drives its Load/Sh/Ad.
//  Samples the ACC multiplier LSB (M) and sequences N add/shift iterations for an NxN unsigned product.
//  Provides a Start/Done handshake to the MIPS datapath. With N=16, ACC width is 2N+1 = 33.
// PARAMETERS
//  N  16  multiplier operand width = number of shift iterations; counter width CW = $clog2(N)
// PORTS
//  Clk    in   1  clock, rising edge
//  Reset  in   1  synchronous, active-high reset
//  St     in   1  start request, level-sensitive
//  M      in   1  ACC bit 0 (current multiplier LSB)
//  Load   out  1  ACC load strobe
//  Sh     out  1  ACC shift-right strobe
//  Ad     out  1  ACC add strobe
//  Done   out  1  product valid in ACC
//  Busy   out  1  high from LOAD through last SHIFT/CHECK
// BEHAVIOUR
//  - Single clock Clk. Reset is synchronous and active-high and has priority over every other input.
//  - On reset: state=IDLE, cnt=0. Load, Sh, Ad, Done and Busy are all 0 in the cycle after the reset edge.
//  - States: IDLE, LOAD, CHECK, SHIFT, DONE. cnt is CW bits wide.
//  - IDLE: all outputs 0. St=1 -> LOAD; otherwise stay. cnt is cleared to 0 in IDLE.
//  - LOAD: Load=1 and Busy=1 for exactly one cycle, then -> CHECK.
//  - CHECK: Busy=1.
//      - M=1: Ad=1, next state SHIFT, cnt unchanged.
//      - M=0: Sh=1, cnt<=cnt+1; if cnt==N-1 -> DONE, else stay in CHECK.
//  - SHIFT: Sh=1, Busy=1, cnt<=cnt+1. If cnt==N-1 -> DONE, else -> CHECK. M is ignored in this state.
//  - DONE: Done=1 and all strobes 0. Holds while St=1; St=0 -> IDLE (4-phase handshake).
//  - Decode rules:
//      - Load/Sh/Ad are decoded from state, plus M in CHECK only.
//      - At most one of Load/Sh/Ad is high in any cycle.
//      - Done and Busy are never high together.
//  - Latency: with Load in cycle L, Done first goes high in cycle L+1+N+popcount(multiplier).
//  - Exactly N Sh pulses and popcount(multiplier) Ad pulses occur per operation.
//  - Boundaries:
//      - cnt never wraps: the transition to DONE occurs on cnt==N-1.
//      - An St glitch during LOAD/CHECK/SHIFT is ignored.
//      - St held high through DONE does not restart; a new op requires St low for >=1 cycle.
//  - Reset mid-operation: IDLE on the next cycle and strobes drop immediately; ACC contents are don't-care afterwards.
// CONFIGURATION
//  MULT_CTRL_ABORT_EN
//   - defined:
//       - adds input port Abort (1 bit).
//       - Abort=1 in LOAD, CHECK or SHIFT -> IDLE next cycle, cnt cleared, Done never asserted.
//       - In that abort cycle Load, Sh and Ad are forced to 0.
//       - Abort is ignored in IDLE and DONE. Reset has priority over Abort.
//   - undefined: no Abort port; an operation always runs to DONE.
// TESTING
//  1 Reset held 3 cycles with St=1 -> all outputs 0; FSM leaves IDLE only after Reset=0 (Load 2 cycles later).
//  2 Multiplier 0x0000, N=16, St pulse -> 1 Load, 16 Sh, 0 Ad; Done at L+17; ACC product 0.
//  3 Multiplier 0xFFFF x 0xFFFF -> 16 Ad, 16 Sh; Done at L+33; ACC = 0x0_FFFE_0001; Load/Sh/Ad one-hot in every cycle.
//  4 Multiplier 0x0005 x 0x0003 -> Ad pulses in iterations 0 and 2 only; Done at L+19; product 0x0000000F.
//  5 St held high after Done -> Done stays high, no second Load; St=0 -> IDLE next cycle; next St starts cleanly.
//  6 Reset asserted at iteration 7 (and Abort at iteration 7 with MULT_CTRL_ABORT_EN) -> IDLE next cycle,
//    no Done, no further strobes; a following op of 0x0003 x 0x0003 yields 9.

Source files
------------

// File: rtl/mult_ctrl.sv
// Control FSM for the shift-add multiplier; drives ACC Load/Sh/Ad.
// Optional Abort input enabled by defining MULT_CTRL_ABORT_EN.
module mult_ctrl #(
   parameter int N = 16
) (
   input  logic Clk,
   input  logic Reset,
`ifdef MULT_CTRL_ABORT_EN
   input  logic Abort,
`endif
   input  logic St,
   input  logic M,
   output logic Load,
   output logic Sh,
   output logic Ad,
   output logic Done,
   output logic Busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      SHIFT,
      DONE
   } state_t;

   state_t         state;
   state_t         nstate;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  ncnt;
   logic           abort;
   logic           active;

   assign active = (state == LOAD) || (state == CHECK) ||
                   (state == SHIFT);

`ifdef MULT_CTRL_ABORT_EN
   assign abort = Abort & active;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
      end
   end

   always_comb begin
      nstate = state;
      ncnt   = cnt;
      Load   = 1'b0;
      Sh     = 1'b0;
      Ad     = 1'b0;
      Done   = 1'b0;
      Busy   = 1'b0;
      unique case (state)
         IDLE: begin
            ncnt = '0;
            if (St) nstate = LOAD;
         end
         LOAD: begin
            Load   = 1'b1;
            Busy   = 1'b1;
            ncnt   = '0;
            nstate = CHECK;
         end
         CHECK: begin
            Busy = 1'b1;
            if (M) begin
               Ad     = 1'b1;
               nstate = SHIFT;
            end else begin
               Sh = 1'b1;
               // hold cnt on the last iteration so it never wraps
               if (cnt == LAST) begin
                  nstate = DONE;
               end else begin
                  ncnt = cnt + 1'b1;
               end
            end
         end
         SHIFT: begin
            Sh   = 1'b1;
            Busy = 1'b1;
            if (cnt == LAST) begin
               nstate = DONE;
            end else begin
               ncnt   = cnt + 1'b1;
               nstate = CHECK;
            end
         end
         DONE: begin
            Done = 1'b1;
            if (!St) nstate = IDLE;
         end
         default: begin
            nstate = IDLE;
            ncnt   = '0;
         end
      endcase

      if (abort) begin
         nstate = IDLE;
         ncnt   = '0;
         Load   = 1'b0;
         Sh     = 1'b0;
         Ad     = 1'b0;
      end

      // strobes drop in the same cycle reset is raised
      if (Reset) begin
         Load = 1'b0;
         Sh   = 1'b0;
         Ad   = 1'b0;
         Done = 1'b0;
         Busy = 1'b0;
      end
   end

endmodule
